fetch1: RTL



---
 rtl/fetch_pkg.sv | 49 ++++
 rtl/fetch1_if.sv | 42 ++++
 rtl/fetch1_btb.sv | 112 +++++++++++
 rtl/fetch1.sv | 107 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared types and constants for the first fetch stage: 2-bit
//             branch counter encodings, BTB entry layout and the default
//             reset PC / BTB geometry.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Default reset PC and BTB index width; the fetch1 top exposes both as
    // overridable parameters.
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam int          BTB_IDX_W_DEF = 6;

    // 2-bit saturating direction counter. The MSB is the taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // One BTB entry. The tag field is sized for the narrowest legal index
    // (pc[31:2]) and holds the real tag zero-extended, so the layout does not
    // depend on the index width chosen by the instantiating module.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        ctr_e        ctr;
    } btb_entry_t;

    // Saturating increment on taken, decrement on not-taken.
    function automatic ctr_e ctr_update(input ctr_e ctr, input logic taken);
        ctr_e res;
        res = ctr;
        case (ctr)
            CTR_SNT: res = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: res = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  res = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  res = taken ? CTR_ST  : CTR_WT;
            default: res = CTR_WNT;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch1_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch1_if
//  Brief    : Control, redirect, BTB-update and fetch-output bundle of the
//             first fetch stage. The slave modport is the fetch1 view; the
//             master modport is the surrounding pipeline view.
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch1_if;

    logic        stall_i;
    logic        branch_mispred_i;
    logic [31:0] mispred_pc_i;
    logic        wasnt_branch_i;
    logic [31:0] wasnt_branch_pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;

    logic [31:0] iaddr_o;
    logic [31:0] pc_o;
    logic        pred_0_o;
    logic        pred_1_o;
    logic        zero_1_o;

    modport slave (
        input  stall_i, branch_mispred_i, mispred_pc_i,
        input  wasnt_branch_i, wasnt_branch_pc_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output iaddr_o, pc_o, pred_0_o, pred_1_o, zero_1_o
    );

    modport master (
        output stall_i, branch_mispred_i, mispred_pc_i,
        output wasnt_branch_i, wasnt_branch_pc_i,
        output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  iaddr_o, pc_o, pred_0_o, pred_1_o, zero_1_o
    );

endinterface
`default_nettype wire

// File: rtl/fetch1_btb.sv
`default_nettype none
// ============================================================================
//  Module   : fetch1_btb
//  Brief    : Direct-mapped branch target buffer with 2-bit counters. Two
//             combinational lookup ports (slot 0 / slot 1) and one update
//             port written at the clock edge. Lookups see the pre-update
//             contents; there is no write-to-read bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch1_btb
    import fetch_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] i_rd0_pc,
    input  wire logic [31:0] i_rd1_pc,
    output logic             o_rd0_taken,
    output logic [31:0]      o_rd0_target,
    output logic             o_rd1_taken,
    output logic [31:0]      o_rd1_target,
    input  wire logic        i_upd_valid,
    input  wire logic [31:0] i_upd_pc,
    input  wire logic        i_upd_taken,
    input  wire logic [31:0] i_upd_target
);

    localparam int ENTRIES = 1 << IDX_W;

    // Valid bits and counters are reset; tags and targets only matter once
    // their valid bit is set, so they carry no reset.
    logic [ENTRIES-1:0]       r_valid;
    logic [ENTRIES-1:0][1:0]  r_ctr;
    logic [29:0]              r_tag [ENTRIES];
    logic [29:0]              r_tgt [ENTRIES];

    logic [IDX_W-1:0] w_rd0_idx;
    logic [IDX_W-1:0] w_rd1_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [29:0]      w_rd0_tag;
    logic [29:0]      w_rd1_tag;
    logic [29:0]      w_upd_tag;
    logic             w_upd_hit;
    logic             w_wr_en;
    btb_entry_t       w_wr_entry;
    logic             w_unused_bits;

    assign w_rd0_idx = i_rd0_pc[IDX_W+1:2];
    assign w_rd1_idx = i_rd1_pc[IDX_W+1:2];
    assign w_upd_idx = i_upd_pc[IDX_W+1:2];
    assign w_rd0_tag = 30'(i_rd0_pc[31:IDX_W+2]);
    assign w_rd1_tag = 30'(i_rd1_pc[31:IDX_W+2]);
    assign w_upd_tag = 30'(i_upd_pc[31:IDX_W+2]);

    // Byte-offset bits never take part in indexing, tagging or targets.
    assign w_unused_bits = ^{i_rd0_pc[1:0], i_rd1_pc[1:0],
                             i_upd_pc[1:0], i_upd_target[1:0]};

    // Lookup ports: taken when the entry is valid, tags match and the
    // counter MSB is set. Indices of the two slots are read independently,
    // so entry 63 followed by entry 0 needs no special handling.
    always_comb begin
        o_rd0_taken  = r_valid[w_rd0_idx] && (r_tag[w_rd0_idx] == w_rd0_tag)
                       && r_ctr[w_rd0_idx][1];
        o_rd1_taken  = r_valid[w_rd1_idx] && (r_tag[w_rd1_idx] == w_rd1_tag)
                       && r_ctr[w_rd1_idx][1];
        o_rd0_target = {r_tgt[w_rd0_idx], 2'b00};
        o_rd1_target = {r_tgt[w_rd1_idx], 2'b00};
    end

    // Update port: build the new entry image; hits train the counter (and
    // retarget on taken), taken misses allocate, not-taken misses are ignored.
    always_comb begin
        w_upd_hit  = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
        w_wr_en    = 1'b0;
        w_wr_entry = '{valid:  r_valid[w_upd_idx],
                       tag:    r_tag[w_upd_idx],
                       target: r_tgt[w_upd_idx],
                       ctr:    ctr_e'(r_ctr[w_upd_idx])};
        if (i_upd_valid) begin
            if (w_upd_hit) begin
                w_wr_en        = 1'b1;
                w_wr_entry.ctr = ctr_update(w_wr_entry.ctr, i_upd_taken);
                if (i_upd_taken) begin
                    w_wr_entry.target = i_upd_target[31:2];
                end
            end else if (i_upd_taken) begin
                w_wr_en    = 1'b1;
                w_wr_entry = '{valid:  1'b1,
                               tag:    w_upd_tag,
                               target: i_upd_target[31:2],
                               ctr:    CTR_WT};
            end
        end
    end

    // Storage write; reset wins over any update presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_ctr   <= {ENTRIES{CTR_WNT}};
        end else if (w_wr_en) begin
            r_valid[w_upd_idx] <= w_wr_entry.valid;
            r_ctr[w_upd_idx]   <= w_wr_entry.ctr;
            r_tag[w_upd_idx]   <= w_wr_entry.tag;
            r_tgt[w_upd_idx]   <= w_wr_entry.target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch1.sv
`default_nettype none
// ============================================================================
//  Module   : fetch1
//  Brief    : First fetch stage. Owns the fetch PC, drives the imem read
//             address, predicts both slots of the fetched pair through the
//             BTB and registers per-slot control so it lines up with the
//             idata returned one cycle later. Downstream redirects override
//             stall.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch1
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BTB_IDX_W = BTB_IDX_W_DEF
) (
    input  wire logic clock_i,
    input  wire logic reset_i,
    fetch1_if.slave   bus
);

    logic [31:0] r_pc;
    logic [31:0] r_pc_o;
    logic        r_pred_0;
    logic        r_pred_1;
    logic        r_zero_1;

    logic [31:0] w_pc_p4;
    logic [31:0] w_pc_p8;
    logic [31:0] w_pc_next;
    logic        w_l0_taken;
    logic        w_l1_taken;
    logic [31:0] w_l0_target;
    logic [31:0] w_l1_target;
    logic        w_redirect;

    assign w_pc_p4    = r_pc + 32'd4;
    assign w_pc_p8    = r_pc + 32'd8;
    assign w_redirect = bus.branch_mispred_i || bus.wasnt_branch_i;

    fetch1_btb #(
        .IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk          (clock_i),
        .rst          (reset_i),
        .i_rd0_pc     (r_pc),
        .i_rd1_pc     (w_pc_p4),
        .o_rd0_taken  (w_l0_taken),
        .o_rd0_target (w_l0_target),
        .o_rd1_taken  (w_l1_taken),
        .o_rd1_target (w_l1_target),
        .i_upd_valid  (bus.upd_valid_i),
        .i_upd_pc     (bus.upd_pc_i),
        .i_upd_taken  (bus.upd_taken_i),
        .i_upd_target (bus.upd_target_i)
    );

    // Next-PC selection: redirects first, then stall, then predictions,
    // then the sequential pair step (wraps naturally at 2^32).
    always_comb begin
        w_pc_next = w_pc_p8;
        if (bus.branch_mispred_i) begin
            w_pc_next = bus.mispred_pc_i;
        end else if (bus.wasnt_branch_i) begin
            w_pc_next = bus.wasnt_branch_pc_i;
        end else if (bus.stall_i) begin
            w_pc_next = r_pc;
        end else if (w_l0_taken) begin
            w_pc_next = w_l0_target;
        end else if (w_l1_taken) begin
            w_pc_next = w_l1_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Per-slot control for the pair whose data arrives next cycle. A redirect
    // kills the in-flight pair; a stall holds the current values.
    always_ff @(posedge clock_i) begin
        if (reset_i || w_redirect) begin
            r_pc_o   <= 32'h0;
            r_pred_0 <= 1'b0;
            r_pred_1 <= 1'b0;
            r_zero_1 <= 1'b0;
        end else if (!bus.stall_i) begin
            r_pc_o   <= r_pc;
            r_pred_0 <= w_l0_taken;
            r_pred_1 <= w_l1_taken && !w_l0_taken;
            r_zero_1 <= w_l0_taken;
        end
    end

    assign bus.iaddr_o  = r_pc;
    assign bus.pc_o     = r_pc_o;
    assign bus.pred_0_o = r_pred_0;
    assign bus.pred_1_o = r_pred_1;
    assign bus.zero_1_o = r_zero_1;

endmodule
`default_nettype wire
